// File: rtl/io_input_port.sv
// Switch/key input front end: 2-flop sync, per-bit debounce, key press latching, DMA read port.
// Define IO_INPUT_IRQ_EN to drive io_int from the pending key events; otherwise io_int is tied low.
module io_input_port #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic        physical_clock,
  input  logic        reset,
  input  logic [17:0] sw_pin,
  input  logic [3:0]  key_pin,
  input  logic        rd_req,
  input  logic        rd_clr,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic [21:0] io_in,
  output logic        io_int
);

  localparam int N = 22;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]  raw;
  logic [N-1:0]  sync1_reg;
  logic [N-1:0]  sync2_reg;
  logic [N-1:0]  db_vec;
  logic [3:0]    key_db;
  logic [3:0]    key_db_d_reg;
  logic [3:0]    pend_reg;
  logic [3:0]    pend_next;
  logic [3:0]    key_rise;
  logic [3:0]    clr_mask;
  logic          rd_valid_reg;
  logic [31:0]   rd_data_reg;

  // Keys are active-low at the pin; everything downstream is active-high.
  assign raw = {~key_pin, sw_pin};

  always_ff @(posedge physical_clock) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_db
      logic [CNT_W-1:0] cnt_reg;
      logic             db_reg;

      // The counter clears on agreement or on commit, so it can never wrap.
      always_ff @(posedge physical_clock) begin
        if (reset) begin
          cnt_reg <= '0;
          db_reg  <= 1'b0;
        end else if (sync2_reg[gi] == db_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          db_reg  <= sync2_reg[gi];
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign db_vec[gi] = db_reg;
    end
  endgenerate

  assign key_db = db_vec[21:18];

  // A clearing read drops the bits it returns, but a press in the same cycle still lands.
  always_comb begin
    key_rise  = key_db & ~key_db_d_reg;
    clr_mask  = (rd_req && rd_clr) ? pend_reg : 4'b0000;
    pend_next = (pend_reg & ~clr_mask) | key_rise;
  end

  always_ff @(posedge physical_clock) begin
    if (reset) begin
      key_db_d_reg <= '0;
      pend_reg     <= '0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      key_db_d_reg <= key_db;
      pend_reg     <= pend_next;
      rd_valid_reg <= rd_req;
      if (rd_req) begin
        rd_data_reg <= {6'b0, pend_reg, db_vec};
      end
    end
  end

  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
  assign io_in    = db_vec;

`ifdef IO_INPUT_IRQ_EN
  assign io_int = |pend_reg;
`else
  assign io_int = 1'b0;
`endif

endmodule

// File: tb/tb_io_input_port.sv
// Directed bench for io_input_port with a short debounce window (8 cycles).
module tb_io_input_port;

  localparam int DB = 8;

`ifdef IO_INPUT_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] sw_pin;
  logic [3:0]  key_pin;
  logic        rd_req;
  logic        rd_clr;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [21:0] io_in;
  logic        io_int;

  int checks = 0;
  int errors = 0;

  io_input_port #(.DEBOUNCE_CYCLES(DB), .CNT_W(4)) dut (
    .physical_clock(clk),
    .reset(reset),
    .sw_pin(sw_pin),
    .key_pin(key_pin),
    .rd_req(rd_req),
    .rd_clr(rd_clr),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .io_in(io_in),
    .io_int(io_int)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; sw_pin = 18'h3FFFF; key_pin = 4'h0; rd_req = 1'b0; rd_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rd_valid !== 1'b0 || rd_data !== 32'h0 || io_in !== 22'h0 || io_int !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: rd_valid=%b rd_data=%h io_in=%h io_int=%b, required all 0",
                 i, rd_valid, rd_data, io_in, io_int);
      end
    end
    sw_pin = 18'h0; key_pin = 4'hF; reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (io_in !== 22'h0 || io_int !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: io_in=%h io_int=%b, required 0/0", io_in, io_int);
    end
  endtask

  task automatic test_debounce();
    // Glitch of 5 cycles must never reach io_in.
    sw_pin[5] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    sw_pin[5] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (io_in !== 22'h0) begin
        errors++;
        $display("FAIL glitch_filter cycle %0d: io_in=%h, required 000000", i, io_in);
      end
    end
    // Held high: committed exactly 2 + DB edges after the pin change.
    sw_pin[5] = 1'b1;
    for (int i = 0; i < DB + 1; i++) tick();
    checks++;
    if (io_in[5] !== 1'b0) begin
      errors++;
      $display("FAIL sw5_early: io_in[5]=%b, required 0 after 9 cycles", io_in[5]);
    end
    tick();
    checks++;
    if (io_in !== 22'h000020) begin
      errors++;
      $display("FAIL sw5_commit: io_in=%h, required 000020 after 10 cycles", io_in);
    end
  endtask

  task automatic test_key_press();
    key_pin[2] = 1'b0;
    for (int i = 0; i < DB + 1; i++) tick();
    checks++;
    if (io_in[20] !== 1'b0) begin
      errors++;
      $display("FAIL key2_early: io_in[20]=%b, required 0", io_in[20]);
    end
    tick();
    checks++;
    if (io_in[20] !== 1'b1 || io_int !== 1'b0) begin
      errors++;
      $display("FAIL key2_db: io_in[20]=%b io_int=%b, required 1/0", io_in[20], io_int);
    end
    tick();
    checks++;
    if (io_int !== IRQ_EXP) begin
      errors++;
      $display("FAIL key2_irq: io_int=%b, required %b", io_int, IRQ_EXP);
    end
    rd_req = 1'b1; rd_clr = 1'b1;
    tick();
    rd_req = 1'b0; rd_clr = 1'b0;
    $display("read clr=1 valid=%b data=%h", rd_valid, rd_data);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h01100020) begin
      errors++;
      $display("FAIL key2_read: rd_valid=%b rd_data=%h, required 1/01100020", rd_valid, rd_data);
    end
    checks++;
    if (io_int !== 1'b0) begin
      errors++;
      $display("FAIL key2_cleared_irq: io_int=%b, required 0", io_int);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'h01100020) begin
      errors++;
      $display("FAIL key2_hold: rd_valid=%b rd_data=%h, required 0/01100020", rd_valid, rd_data);
    end
    // Release: debounced low, and no new pending event.
    key_pin[2] = 1'b1;
    for (int i = 0; i < DB + 4; i++) tick();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    $display("read clr=0 valid=%b data=%h", rd_valid, rd_data);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h00000020) begin
      errors++;
      $display("FAIL key2_release: rd_valid=%b rd_data=%h, required 1/00000020", rd_valid, rd_data);
    end
  endtask

  task automatic test_collision();
    key_pin[0] = 1'b0;
    for (int i = 0; i < DB + 2; i++) tick();
    // key_db[0] has just risen; the press edge is live during this cycle.
    rd_req = 1'b1; rd_clr = 1'b1;
    tick();
    rd_req = 1'b1; rd_clr = 1'b0;
    $display("read clr=1 valid=%b data=%h", rd_valid, rd_data);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h00040020) begin
      errors++;
      $display("FAIL collision_read: rd_valid=%b rd_data=%h, required 1/00040020", rd_valid, rd_data);
    end
    tick();
    rd_req = 1'b0;
    $display("read clr=0 valid=%b data=%h", rd_valid, rd_data);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h00440020 || io_int !== IRQ_EXP) begin
      errors++;
      $display("FAIL collision_pend: rd_valid=%b rd_data=%h io_int=%b, required 1/00440020/%b",
               rd_valid, rd_data, io_int, IRQ_EXP);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    rd_req = 1'b1; rd_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      $display("read b2b %0d valid=%b data=%h", i, rd_valid, rd_data);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 32'h00440020) begin
        errors++;
        $display("FAIL b2b_%0d: rd_valid=%b rd_data=%h, required 1/00440020", i, rd_valid, rd_data);
      end
    end
    rd_req = 1'b0;
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'h00440020 || io_int !== IRQ_EXP) begin
      errors++;
      $display("FAIL b2b_end: rd_valid=%b rd_data=%h io_int=%b, required 0/00440020/%b",
               rd_valid, rd_data, io_int, IRQ_EXP);
    end
  endtask

  task automatic test_reset_read();
    reset = 1'b1; rd_req = 1'b1;
    tick();
    reset = 1'b0; rd_req = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'h0 || io_in !== 22'h0 || io_int !== 1'b0) begin
      errors++;
      $display("FAIL reset_read: rd_valid=%b rd_data=%h io_in=%h io_int=%b, required all 0",
               rd_valid, rd_data, io_in, io_int);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_read_after: rd_valid=%b, required 0", rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_key_press();
    test_collision();
    test_back_to_back();
    test_reset_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_input_port.md
# io_input_port

Input-side front end for the board switches and push-buttons. It synchronizes and debounces the 18 slide switches and 4 keys, detects key presses, and latches them as pending events. It then serves the DMA's IO read requests through a single-cycle request/valid handshake. It is the read end of the IO bus whose write end drives the LEDs and 7-segment displays, and it replaces the raw IO_input wiring into the DMA.

## Interface
- DEBOUNCE_CYCLES, 500000: number of consecutive stable cycles required before a debounced value changes (10 ms at 50 MHz); minimum 2.
- CNT_W, 20: width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- physical_clock  input  1  50 MHz system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- sw_pin  input  18  raw slide switches, active-high, asynchronous.
- key_pin  input  4  raw push-buttons, active-low at the pin, asynchronous.
- rd_req  input  1  DMA read strobe, sampled each cycle.
- rd_clr  input  1  with rd_req: clear the pending-event bits that were returned.
- rd_valid  output  1  one-cycle pulse; rd_data is valid.
- rd_data  output  32  {6'b0, pend[3:0], key_db[3:0], sw_db[17:0]}.
- io_in  output  22  live debounced image {key_db, sw_db}, a drop-in for IO_input.
- io_int  output  1  level interrupt request while any pending bit is set (see Configuration).

## Operation
- Synchronizer: two-flop chain per bit on sw_pin and on the inverted key_pin. Key values are active-high internally.
- Debounce, per bit (22 independent channels):
  - A CNT_W counter and a debounced register per channel.
  - Synchronized value equals the debounced value: counter cleared.
  - Otherwise: counter increments.
  - Counter reaches DEBOUNCE_CYCLES-1 while values still differ: debounced bit takes the synchronized value and the counter clears.
  - The counter never wraps.
- Press detect: key_db rising edge sets pend[i]. Release sets nothing.
- Read handshake:
  - rd_req=1 in cycle N gives rd_valid=1 in cycle N+1 only.
  - rd_data captures sw_db, key_db and pend as they stood at the edge ending cycle N.
  - rd_data holds that value until the next read.
  - If rd_clr=1, the pend bits returned are cleared at that same edge.
  - Back-to-back rd_req every cycle is legal; one rd_valid follows each request.
- Simultaneous events: a press edge in the same cycle as a clearing read leaves that pend bit set; the set wins. The read returns the pre-set value, so no event is lost.
- pend bits saturate. Repeated presses before a read are reported once.

## Timing
- Reset values:
  - rd_valid=0, rd_data=0, io_in=0, io_int=0.
  - pend=0, all counters 0, all debounced registers 0, synchronizer flops 0.
- Reset has priority over every other input in the same cycle.
- Reset asserted mid-debounce discards partial counts. A read issued in the reset cycle gets no rd_valid.
- After reset, a key held down reports pressed after sync + DEBOUNCE_CYCLES and sets pend, which counts as a press event.
- Pin change to debounced change: 2 sync cycles + DEBOUNCE_CYCLES cycles. A glitch shorter than DEBOUNCE_CYCLES is filtered.
- Debounced change to pend set: 1 cycle. pend set to io_int high: 0 cycles (combinational from pend).
- Request to data: 1 cycle, fixed.

## Configuration
- IO_INPUT_IRQ_EN defined:
  - io_int = |pend (registered pend, no extra delay).
  - Intended to be ORed into the scheduler's operation-interrupt path.
- IO_INPUT_IRQ_EN undefined:
  - io_int is tied to 0.
  - pend and the read handshake behave identically; software polls rd_data[25:22].

## Test plan
- Reset: assert reset 3 cycles with switches at 0x3FFFF and all keys held down → every output 0 during reset.
- Debounce (DEBOUNCE_CYCLES=8): sw_pin[5] toggled 5 cycles then restored → io_in unchanged. Held high → io_in[5]=1 exactly 10 cycles after the pin edge.
- Key press:
  - key_pin[2] driven low and held → pend[2]=1 one cycle after key_db[2] rises.
  - With the macro defined, io_int=1 at that point.
  - rd_req with rd_clr=1 → next cycle rd_valid=1 and rd_data[24]=1, rd_data[20]=1; pend then 0 and io_int 0.
- Collision: key_db[0] rises in the same cycle as a clearing read → returned rd_data[22]=0 and pend[0]=1 afterward.
- Back-to-back: rd_req high 4 consecutive cycles with rd_clr=0 → 4 consecutive rd_valid pulses with identical rd_data, pend unchanged.
- Macro off: repeat the key-press case → io_int stays 0 throughout and rd_data still reports pend[2]=1.
